// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if
//   Groups the instruction-memory, hazard, redirect and IF/ID signals of the
//   instruction-fetch unit into one bundle. clk/reset stay plain module ports.
//
//   Signals:
//     imem_address      fetch unit -> imem   byte address (= fetch PC)
//     imem_read_instr   imem -> fetch unit   word for last cycle's address
//     stall             hazard -> fetch      hold IF/ID and PC
//     redirect          EX -> fetch          branch taken / jump
//     redirect_target   EX -> fetch          new PC
//     if_id_valid       fetch -> ID          IF/ID holds a live instruction
//     if_id_pc          fetch -> ID          PC of if_id_instr
//     if_id_instr       fetch -> ID          instruction or NOP bubble
//     misaligned_target fetch -> EX/trap     pulse: accepted target not word aligned
//
//   Modports:
//     master  the fetch unit side
//     slave   the pipeline/memory environment side
interface if_fetch_unit_if;
    logic [31:0] imem_address;
    logic [31:0] imem_read_instr;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        misaligned_target;

    modport master (
        output imem_address,
        input  imem_read_instr,
        input  stall,
        input  redirect,
        input  redirect_target,
        output if_id_valid,
        output if_id_pc,
        output if_id_instr,
        output misaligned_target
    );

    modport slave (
        input  imem_address,
        output imem_read_instr,
        output stall,
        output redirect,
        output redirect_target,
        input  if_id_valid,
        input  if_id_pc,
        input  if_id_instr,
        input  misaligned_target
    );
endinterface

// File: rtl/if_fetch_unit.sv
// if_fetch_unit
//   Instruction-fetch initiator for the 5-stage RV32 pipeline. Owns the PC,
//   drives a synchronous (1-cycle latency) instruction memory, pairs each
//   returned word with the PC that requested it, and loads the IF/ID register.
//   A hazard stall parks the in-flight response in a 1-entry hold buffer so
//   multi-cycle stalls lose and duplicate nothing. An EX redirect squashes the
//   in-flight response and the hold buffer and restarts fetch at the target.
//
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high reset
//     bus    if_fetch_unit_if.master (memory, hazard, redirect, IF/ID signals)
//
//   Parameters:
//     RESET_PC   PC loaded on reset
//     NOP_INSTR  instruction word presented with bubbles (addi x0,x0,0)
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    if_fetch_unit_if.master bus
);

    // Cycle action, resolved with priority redirect > stall > normal.
    typedef enum logic [1:0] {
        ACT_ISSUE    = 2'd0,
        ACT_STALL    = 2'd1,
        ACT_REDIRECT = 2'd2
    } action_e;

    action_e     action;

    logic [31:0] fetch_pc_q,   fetch_pc_d;
    logic        rsp_valid_q,  rsp_valid_d;
    logic [31:0] rsp_pc_q,     rsp_pc_d;
    logic        hold_valid_q, hold_valid_d;
    logic [31:0] hold_pc_q,    hold_pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_pc_q,    ifid_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        misalign_q,   misalign_d;

    always_comb begin
        if (bus.redirect) begin
            action = ACT_REDIRECT;
        end else if (bus.stall) begin
            action = ACT_STALL;
        end else begin
            action = ACT_ISSUE;
        end
    end

    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_pc_d     = rsp_pc_q;
        hold_valid_d = hold_valid_q;
        hold_pc_d    = hold_pc_q;
        hold_instr_d = hold_instr_q;
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        misalign_d   = 1'b0;

        unique case (action)
            ACT_REDIRECT: begin
                // Low target bits are dropped for fetch and reported instead.
                fetch_pc_d   = {bus.redirect_target[31:2], 2'b00};
                rsp_valid_d  = 1'b0;
                hold_valid_d = 1'b0;
                ifid_valid_d = 1'b0;
                ifid_instr_d = NOP_INSTR;
                misalign_d   = (bus.redirect_target[1:0] != 2'b00);
            end

            ACT_STALL: begin
                // No request issued; the word arriving now must be parked
                // because it will not be presented again.
                rsp_valid_d = 1'b0;
                if (rsp_valid_q && !hold_valid_q) begin
                    hold_valid_d = 1'b1;
                    hold_pc_d    = rsp_pc_q;
                    hold_instr_d = bus.imem_read_instr;
                end
            end

            default: begin
                rsp_valid_d = 1'b1;
                rsp_pc_d    = fetch_pc_q;
                fetch_pc_d  = fetch_pc_q + 32'd4;

                // The hold buffer is older than any live response, so it
                // drains first; both cannot be valid at once.
                if (hold_valid_q) begin
                    ifid_valid_d = 1'b1;
                    ifid_pc_d    = hold_pc_q;
                    ifid_instr_d = hold_instr_q;
                    hold_valid_d = 1'b0;
                end else if (rsp_valid_q) begin
                    ifid_valid_d = 1'b1;
                    ifid_pc_d    = rsp_pc_q;
                    ifid_instr_d = bus.imem_read_instr;
                end else begin
                    ifid_valid_d = 1'b0;
                    ifid_instr_d = NOP_INSTR;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q   <= RESET_PC;
            rsp_valid_q  <= 1'b0;
            rsp_pc_q     <= '0;
            hold_valid_q <= 1'b0;
            hold_pc_q    <= '0;
            hold_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= '0;
            ifid_instr_q <= NOP_INSTR;
            misalign_q   <= 1'b0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_pc_q     <= rsp_pc_d;
            hold_valid_q <= hold_valid_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            misalign_q   <= misalign_d;
        end
    end

    assign bus.imem_address      = fetch_pc_q;
    assign bus.if_id_valid       = ifid_valid_q;
    assign bus.if_id_pc          = ifid_pc_q;
    assign bus.if_id_instr       = ifid_instr_q;
    assign bus.misaligned_target = misalign_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit
//   Self-checking bench for if_fetch_unit: a directed vector table covering
//   reset, stalls, redirects, wrap and mid-stream reset, then a randomized
//   phase compared against a queue-based reference model.
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic clk;
    logic reset;

    if_fetch_unit_if bus ();

    if_fetch_unit #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: three fixed words, a unique pattern elsewhere.
    function automatic logic [31:0] memfn(input logic [31:0] a);
        if (a == 32'h0)      return 32'h0050_0093;
        else if (a == 32'h4) return 32'h00A0_0113;
        else if (a == 32'h8) return 32'h0020_81B3;
        else                 return 32'hC0DE_0000 ^ a;
    endfunction

    // Synchronous memory with 1-cycle read latency.
    always @(posedge clk) bus.imem_read_instr <= memfn(bus.imem_address);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %08h expected %08h", name, $time, act, exp);
        end
    endtask

    // Reference model: issued-but-undelivered PCs wait in a queue; a normal
    // cycle delivers the oldest and issues the next PC, a stall freezes
    // everything, a redirect empties the queue.
    logic [31:0] m_fetch;
    logic [31:0] m_q[$];
    logic        m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic        m_mis;

    task automatic model_edge(input logic rst, input logic st, input logic rd, input logic [31:0] tgt);
        logic [31:0] p;
        if (rst) begin
            m_fetch = RESET_PC;
            m_q.delete();
            m_valid = 1'b0;
            m_pc    = '0;
            m_instr = NOP_INSTR;
            m_mis   = 1'b0;
        end else if (rd) begin
            m_fetch = {tgt[31:2], 2'b00};
            m_q.delete();
            m_valid = 1'b0;
            m_instr = NOP_INSTR;
            m_mis   = (tgt[1:0] != 2'b00);
        end else begin
            m_mis = 1'b0;
            if (!st) begin
                if (m_q.size() > 0) begin
                    p       = m_q.pop_front();
                    m_valid = 1'b1;
                    m_pc    = p;
                    m_instr = memfn(p);
                end else begin
                    m_valid = 1'b0;
                    m_instr = NOP_INSTR;
                end
                m_q.push_back(m_fetch);
                m_fetch = m_fetch + 32'd4;
            end
        end
    endtask

    typedef struct {
        logic        rst;
        logic        st;
        logic        rd;
        logic [31:0] tgt;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_addr;
        logic        e_mis;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst, input logic st, input logic rd, input logic [31:0] tgt,
                       input logic ev, input logic [31:0] epc, input logic [31:0] ein,
                       input logic [31:0] ea, input logic em);
        vec_t v;
        v.rst = rst; v.st = st; v.rd = rd; v.tgt = tgt;
        v.e_valid = ev; v.e_pc = epc; v.e_instr = ein; v.e_addr = ea; v.e_mis = em;
        vq.push_back(v);
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, settle.
    task automatic step(input logic rst, input logic st, input logic rd, input logic [31:0] tgt);
        reset               = rst;
        bus.stall           = st;
        bus.redirect        = rd;
        bus.redirect_target = tgt;
        @(posedge clk);
        model_edge(rst, st, rd, tgt);
        #1;
    endtask

    initial begin
        reset               = 1'b1;
        bus.stall           = 1'b0;
        bus.redirect        = 1'b0;
        bus.redirect_target = '0;

        //   rst st rd target        valid pc            instr          addr          mis
        add(1, 0, 0, 32'h0,          0, 32'h0,         NOP_INSTR,     32'h0,        0); // reset
        add(0, 0, 0, 32'h0,          0, 32'h0,         NOP_INSTR,     32'h4,        0);
        add(0, 0, 0, 32'h0,          1, 32'h0,         32'h0050_0093, 32'h8,        0);
        add(0, 0, 0, 32'h0,          1, 32'h4,         32'h00A0_0113, 32'hC,        0);
        add(0, 1, 0, 32'h0,          1, 32'h4,         32'h00A0_0113, 32'hC,        0); // 1-cycle stall
        add(0, 0, 0, 32'h0,          1, 32'h8,         32'h0020_81B3, 32'h10,       0);
        add(0, 0, 0, 32'h0,          1, 32'hC,         32'hC0DE_000C, 32'h14,       0);
        add(0, 1, 0, 32'h0,          1, 32'hC,         32'hC0DE_000C, 32'h14,       0); // 3-cycle stall
        add(0, 1, 0, 32'h0,          1, 32'hC,         32'hC0DE_000C, 32'h14,       0);
        add(0, 1, 0, 32'h0,          1, 32'hC,         32'hC0DE_000C, 32'h14,       0);
        add(0, 0, 0, 32'h0,          1, 32'h10,        32'hC0DE_0010, 32'h18,       0);
        add(0, 0, 0, 32'h0,          1, 32'h14,        32'hC0DE_0014, 32'h1C,       0);
        add(0, 0, 1, 32'h40,         0, 32'h14,        NOP_INSTR,     32'h40,       0); // redirect
        add(0, 0, 0, 32'h0,          0, 32'h14,        NOP_INSTR,     32'h44,       0);
        add(0, 0, 0, 32'h0,          1, 32'h40,        32'hC0DE_0040, 32'h48,       0);
        add(0, 0, 0, 32'h0,          1, 32'h44,        32'hC0DE_0044, 32'h4C,       0);
        add(0, 1, 1, 32'h22,         0, 32'h44,        NOP_INSTR,     32'h20,       1); // redirect+stall, misaligned
        add(0, 0, 0, 32'h0,          0, 32'h44,        NOP_INSTR,     32'h24,       0);
        add(0, 0, 0, 32'h0,          1, 32'h20,        32'hC0DE_0020, 32'h28,       0);
        add(0, 0, 0, 32'h0,          1, 32'h24,        32'hC0DE_0024, 32'h2C,       0);
        add(0, 1, 0, 32'h0,          1, 32'h24,        32'hC0DE_0024, 32'h2C,       0); // hold gets pc 0x28
        add(1, 0, 0, 32'h0,          0, 32'h0,         NOP_INSTR,     32'h0,        0); // reset mid-stream
        add(0, 0, 0, 32'h0,          0, 32'h0,         NOP_INSTR,     32'h4,        0);
        add(0, 0, 0, 32'h0,          1, 32'h0,         32'h0050_0093, 32'h8,        0);
        add(0, 0, 1, 32'hFFFF_FFFC,  0, 32'h0,         NOP_INSTR,     32'hFFFF_FFFC, 0); // wrap
        add(0, 0, 0, 32'h0,          0, 32'h0,         NOP_INSTR,     32'h0,        0);
        add(0, 0, 0, 32'h0,          1, 32'hFFFF_FFFC, 32'h3F21_FFFC, 32'h4,        0);
        add(0, 0, 0, 32'h0,          1, 32'h0,         32'h0050_0093, 32'h8,        0);
        add(0, 0, 1, 32'h100,        0, 32'h0,         NOP_INSTR,     32'h100,      0); // back-to-back redirects
        add(0, 0, 1, 32'h203,        0, 32'h0,         NOP_INSTR,     32'h200,      1);
        add(0, 0, 0, 32'h0,          0, 32'h0,         NOP_INSTR,     32'h204,      0);
        add(0, 0, 0, 32'h0,          1, 32'h200,       32'hC0DE_0200, 32'h208,      0);

        @(negedge clk);
        foreach (vq[i]) begin
            step(vq[i].rst, vq[i].st, vq[i].rd, vq[i].tgt);
            check($sformatf("vec%0d valid", i), {31'b0, bus.if_id_valid},       {31'b0, vq[i].e_valid});
            check($sformatf("vec%0d pc", i),    bus.if_id_pc,                   vq[i].e_pc);
            check($sformatf("vec%0d instr", i), bus.if_id_instr,                vq[i].e_instr);
            check($sformatf("vec%0d addr", i),  bus.imem_address,               vq[i].e_addr);
            check($sformatf("vec%0d mis", i),   {31'b0, bus.misaligned_target}, {31'b0, vq[i].e_mis});
        end

        // Randomized phase against the reference model.
        for (int c = 0; c < 3000; c++) begin
            logic        r_rst, r_st, r_rd;
            logic [31:0] r_tgt;
            r_rst = ($urandom_range(0, 99) < 2);
            r_st  = ($urandom_range(0, 99) < 30);
            r_rd  = ($urandom_range(0, 99) < 8);
            if ($urandom_range(0, 3) == 0) r_tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else                            r_tgt = $urandom;
            step(r_rst, r_st, r_rd, r_tgt);
            check("rnd valid", {31'b0, bus.if_id_valid},       {31'b0, m_valid});
            check("rnd pc",    bus.if_id_pc,                   m_pc);
            check("rnd instr", bus.if_id_instr,                m_instr);
            check("rnd addr",  bus.imem_address,               m_fetch);
            check("rnd mis",   {31'b0, bus.misaligned_target}, {31'b0, m_mis});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
